operand_entry: RTL and testbench
================================

Name: operand_entry

Overview:
- Front-end stage of the 8-bit calculator. Sits between the push-button inputs and the carry-lookahead adder.
- Turns button presses into two 8-bit hex operands, an add/subtract selection and a result-valid flag.
- Drives the adder's a, b and ci inputs directly, so subtraction is performed as a + ~b + 1.
- Takes the adder sum back in so a new operation can start from the previous result (chaining).

Parameters:
DEBOUNCE_CYCLES, 3, consecutive high samples needed before a key press is accepted; used only when OPERAND_ENTRY_DEBOUNCE_EN is defined.

Ports:
hz100  input  1  system clock (100 Hz)
reset  input  1  synchronous, active-high reset
key_digit  input  16  hex digit buttons 0..F (pb[15:0])
key_add  input  1  select add (pb[16])
key_sub  input  1  select subtract (pb[17])
key_clr  input  1  clear (pb[18])
key_eq  input  1  equals (pb[19])
result  input  8  sum from the adder stage
op_a  output  8  operand A to the adder
op_b  output  8  operand B to the adder; equals ~b_reg when subtracting
op_ci  output  1  adder carry-in; 1 when subtracting
valid  output  1  operands final and result meaningful
disp  output  8  value to show: a_reg in S_A, b_reg in S_B, result in S_DONE
state  output  2  current FSM state, for the LEDs

Behaviour:
- Clock and reset: single clock hz100. Reset is synchronous and active-high.
- Reset values: a_reg, b_reg = 0; sub = 0; state = S_A (2'd0); valid = 0; op_a, op_b, op_ci = 0; disp = 0.
- Key history during reset: the history register loads the live inputs, so a key held through reset release produces no press.
- Reset mid-operation: everything returns to the reset values at the next edge.
- Press detection: press = in & ~in_q, where in_q is registered every cycle. The FSM acts on the same edge, so the register update lands 1 cycle after the button rises.
- Priority when several presses occur in one cycle: clr > eq > sub > add > digit. Among digits, the lowest index wins. Only one action is taken per cycle.
- Digit entry: reg <= {reg[3:0], digit}. A third digit shifts the oldest nibble out (wrap-around by shifting; no error).
- FSM transitions:
  - S_A, digit: shift into a_reg.
  - S_A, add/sub: set sub; clear b_reg; go to S_B.
  - S_A, eq: ignored.
  - S_A, clr: clear a_reg; stay in S_A.
  - S_B, digit: shift into b_reg.
  - S_B, add/sub: change sub only.
  - S_B, eq: go to S_DONE.
  - S_B, clr: full clear; go to S_A.
  - S_DONE, digit: a_reg <= {4'h0, digit}; clear b_reg and sub; go to S_A.
  - S_DONE, add/sub: a_reg <= result (chaining); set sub; clear b_reg; go to S_B.
  - S_DONE, eq: ignored.
  - S_DONE, clr: full clear; go to S_A.
- Combinational outputs from registers:
  - valid = (state == S_DONE).
  - op_a = a_reg.
  - op_b = sub ? ~b_reg : b_reg.
  - op_ci = sub.
- Key release has no effect.

Optional Feature:
- OPERAND_ENTRY_DEBOUNCE_EN defined: each key has a saturating counter. A press is accepted once the input has been high for DEBOUNCE_CYCLES consecutive samples, and fires once per hold. Any low sample resets that key's counter.
- Not defined: raw single-register edge detection; no counters are built.

Decomposition:
- Shared package calc_pkg holds:
  - typedef enum logic [1:0] {S_A, S_B, S_DONE} entry_state_t
  - key index constants KEY_ADD=16, KEY_SUB=17, KEY_CLR=18, KEY_EQ=19
  - DIGIT_W=4
- One sub-module, key_edge, parameterised by width. It holds the history register, reset-load behaviour and the optional debounce logic, and outputs one-cycle press pulses.

Test Plan:
- Press 3, A, add, 1, 5, eq (one press per 4 cycles) -> op_a=8'h3A, op_b=8'h15, op_ci=0, valid=1, state=S_DONE.
- Press 5, 0, sub, 2, 0, eq -> op_a=8'h50, op_b=8'hDF, op_ci=1, valid=1.
- Press 1, 2, 3 from reset -> a_reg=8'h23, disp=8'h23, state=S_A.
- In S_DONE with result=8'h4F, press add -> op_a=8'h4F, b_reg=0, state=S_B, valid=0. Then press digit 9 -> disp=8'h09.
- Digit 7 and clr rising in the same cycle -> everything cleared, a_reg=0. Digit 4 held through reset release -> a_reg stays 0.
- With the macro defined, a 2-cycle pulse on digit 6 -> ignored, and a 3-cycle hold -> a_reg=8'h06. Without the macro, the same 2-cycle pulse -> a_reg=8'h06.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator front end.
package calc_pkg;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_DONE = 2'd2
  } entry_state_t;

  localparam int KEY_W   = 20;
  localparam int KEY_ADD = 16;
  localparam int KEY_SUB = 17;
  localparam int KEY_CLR = 18;
  localparam int KEY_EQ  = 19;
  localparam int DIGIT_W = 4;
  localparam int DATA_W  = 8;

  // Lowest-index pressed digit wins; returns 0 when nothing is pressed.
  function automatic logic [DIGIT_W-1:0] lowest_digit(input logic [15:0] d);
    logic [DIGIT_W-1:0] idx;
    idx = 4'h0;
    for (int i = 15; i >= 0; i--) begin
      if (d[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/operand_entry_key_edge.sv
// key_edge: turns raw key levels into one-cycle press pulses.
// Macro OPERAND_ENTRY_DEBOUNCE_EN selects the counting debouncer;
// otherwise a single history register gives plain rising-edge detection.
module key_edge #(
  parameter int WIDTH           = 20,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] press
);

  if (DEBOUNCE_CYCLES < 1) begin : g_cfg_err
    $error("key_edge: DEBOUNCE_CYCLES must be at least 1");
  end

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r [WIDTH];

  // Per-key saturating high-sample counter; a key held during reset starts saturated
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (!in[i]) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end else if (reset) begin
        cnt_r[i] <= CNT_MAX;
      end else if (cnt_r[i] != CNT_MAX) begin
        cnt_r[i] <= cnt_r[i] + CNT_W'(1);
      end else begin
        cnt_r[i] <= cnt_r[i];
      end
    end
  end

  // Fire on the sample that completes the required run of highs, once per hold
  always_comb begin
    press = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (in[i] && (cnt_r[i] == CNT_FIRE)) begin
        press[i] = 1'b1;
      end else begin
        press[i] = 1'b0;
      end
    end
  end
`else
  logic [WIDTH-1:0] in_q_r;

  // History register; it also tracks the live inputs during reset so a held key is not a press
  always_ff @(posedge clk) begin
    if (reset) begin
      in_q_r <= in;
    end else begin
      in_q_r <= in;
    end
  end

  assign press = in & ~in_q_r;
`endif

endmodule

// File: rtl/operand_entry.sv
// operand_entry: key-driven operand entry FSM feeding the adder stage.
// Optional debounce is enabled by defining OPERAND_ENTRY_DEBOUNCE_EN.
module operand_entry
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic [15:0] key_digit,
  input  logic        key_add,
  input  logic        key_sub,
  input  logic        key_clr,
  input  logic        key_eq,
  input  logic [7:0]  result,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b,
  output logic        op_ci,
  output logic        valid,
  output logic [7:0]  disp,
  output logic [1:0]  state
);

  logic [KEY_W-1:0]   keys_s;
  logic [KEY_W-1:0]   press_s;
  logic               clr_s;
  logic               eq_s;
  logic               sub_s;
  logic               op_s;
  logic               dig_s;
  logic [DIGIT_W-1:0] digit_s;

  entry_state_t       state_r;
  logic [DATA_W-1:0]  a_r;
  logic [DATA_W-1:0]  b_r;
  logic               sub_r;

  assign keys_s = {key_eq, key_clr, key_sub, key_add, key_digit};

  key_edge #(
    .WIDTH          (KEY_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_edge (
    .clk  (hz100),
    .reset(reset),
    .in   (keys_s),
    .press(press_s)
  );

  assign clr_s   = press_s[KEY_CLR];
  assign eq_s    = press_s[KEY_EQ];
  assign sub_s   = press_s[KEY_SUB];
  assign op_s    = press_s[KEY_SUB] | press_s[KEY_ADD];
  assign dig_s   = |press_s[15:0];
  assign digit_s = lowest_digit(press_s[15:0]);

  // Entry FSM: one action per cycle, priority clr > eq > sub/add > digit
  always_ff @(posedge hz100) begin
    if (reset) begin
      state_r <= S_A;
      a_r     <= 8'h00;
      b_r     <= 8'h00;
      sub_r   <= 1'b0;
    end else begin
      case (state_r)
        S_A: begin
          if (clr_s) begin
            a_r <= 8'h00;
          end else if (eq_s) begin
            state_r <= S_A;  // equals has nothing to finish yet
          end else if (op_s) begin
            sub_r   <= sub_s;
            b_r     <= 8'h00;
            state_r <= S_B;
          end else if (dig_s) begin
            a_r <= {a_r[DIGIT_W-1:0], digit_s};
          end
        end
        S_B: begin
          if (clr_s) begin
            a_r     <= 8'h00;
            b_r     <= 8'h00;
            sub_r   <= 1'b0;
            state_r <= S_A;
          end else if (eq_s) begin
            state_r <= S_DONE;
          end else if (op_s) begin
            sub_r <= sub_s;
          end else if (dig_s) begin
            b_r <= {b_r[DIGIT_W-1:0], digit_s};
          end
        end
        S_DONE: begin
          if (clr_s) begin
            a_r     <= 8'h00;
            b_r     <= 8'h00;
            sub_r   <= 1'b0;
            state_r <= S_A;
          end else if (eq_s) begin
            state_r <= S_DONE;  // already showing a result
          end else if (op_s) begin
            a_r     <= result;  // chain from the previous result
            sub_r   <= sub_s;
            b_r     <= 8'h00;
            state_r <= S_B;
          end else if (dig_s) begin
            a_r     <= {{(DATA_W-DIGIT_W){1'b0}}, digit_s};
            b_r     <= 8'h00;
            sub_r   <= 1'b0;
            state_r <= S_A;
          end
        end
        default: begin
          state_r <= S_A;
        end
      endcase
    end
  end

  assign op_a  = a_r;
  assign op_b  = sub_r ? ~b_r : b_r;
  assign op_ci = sub_r;
  assign valid = (state_r == S_DONE);
  assign state = state_r;

  // Display selection follows the entry phase
  always_comb begin
    disp = 8'h00;
    case (state_r)
      S_A:     disp = a_r;
      S_B:     disp = b_r;
      S_DONE:  disp = result;
      default: disp = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_operand_entry.sv
// Directed self-checking bench for operand_entry.
module tb_operand_entry;

  logic        hz100;
  logic        reset;
  logic [19:0] keys;
  logic [7:0]  result;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        op_ci;
  logic        valid;
  logic [7:0]  disp;
  logic [1:0]  state;

  int checks;
  int errors;

`ifdef OPERAND_ENTRY_DEBOUNCE_EN
  localparam int HOLD = 3;
`else
  localparam int HOLD = 1;
`endif

  localparam logic [19:0] KADD = 20'h10000;
  localparam logic [19:0] KSUB = 20'h20000;
  localparam logic [19:0] KCLR = 20'h40000;
  localparam logic [19:0] KEQ  = 20'h80000;

  operand_entry dut (
    .hz100    (hz100),
    .reset    (reset),
    .key_digit(keys[15:0]),
    .key_add  (keys[16]),
    .key_sub  (keys[17]),
    .key_clr  (keys[18]),
    .key_eq   (keys[19]),
    .result   (result),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_ci    (op_ci),
    .valid    (valid),
    .disp     (disp),
    .state    (state)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  function automatic logic [19:0] dig(input int d);
    logic [19:0] m;
    m = 20'h00001;
    return m << d;
  endfunction

  task automatic press(input logic [19:0] m);
    @(negedge hz100);
    keys = keys | m;
    repeat (HOLD) @(negedge hz100);
    keys = keys & ~m;
    repeat (2) @(negedge hz100);
  endtask

  task automatic do_reset();
    @(negedge hz100);
    reset = 1'b1;
    keys  = 20'h00000;
    repeat (2) @(negedge hz100);
    reset = 1'b0;
    @(negedge hz100);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (op_a !== 8'h00) begin errors++; $display("FAIL reset_op_a got %h exp 00", op_a); end
    checks++; if (op_b !== 8'h00) begin errors++; $display("FAIL reset_op_b got %h exp 00", op_b); end
    checks++; if (op_ci !== 1'b0) begin errors++; $display("FAIL reset_op_ci got %b exp 0", op_ci); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (disp !== 8'h00) begin errors++; $display("FAIL reset_disp got %h exp 00", disp); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
  endtask

  task automatic test_add();
    do_reset();
    press(dig(3)); press(dig(10)); press(KADD); press(dig(1)); press(dig(5)); press(KEQ);
    checks++; if (op_a !== 8'h3A) begin errors++; $display("FAIL add_op_a got %h exp 3a", op_a); end
    checks++; if (op_b !== 8'h15) begin errors++; $display("FAIL add_op_b got %h exp 15", op_b); end
    checks++; if (op_ci !== 1'b0) begin errors++; $display("FAIL add_op_ci got %b exp 0", op_ci); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", valid); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL add_state got %0d exp 2", state); end
  endtask

  task automatic test_sub();
    do_reset();
    press(dig(5)); press(dig(0)); press(KSUB); press(dig(2)); press(dig(0)); press(KEQ);
    checks++; if (op_a !== 8'h50) begin errors++; $display("FAIL sub_op_a got %h exp 50", op_a); end
    checks++; if (op_b !== 8'hDF) begin errors++; $display("FAIL sub_op_b got %h exp df", op_b); end
    checks++; if (op_ci !== 1'b1) begin errors++; $display("FAIL sub_op_ci got %b exp 1", op_ci); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL sub_valid got %b exp 1", valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    press(dig(1)); press(dig(2)); press(dig(3));
    checks++; if (op_a !== 8'h23) begin errors++; $display("FAIL wrap_op_a got %h exp 23", op_a); end
    checks++; if (disp !== 8'h23) begin errors++; $display("FAIL wrap_disp got %h exp 23", disp); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL wrap_state got %0d exp 0", state); end
    press(KEQ);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL eq_in_a_state got %0d exp 0", state); end
  endtask

  task automatic test_chain();
    do_reset();
    press(dig(3)); press(dig(10)); press(KADD); press(dig(1)); press(dig(5)); press(KEQ);
    result = 8'h4F;
    @(negedge hz100);
    checks++; if (disp !== 8'h4F) begin errors++; $display("FAIL done_disp got %h exp 4f", disp); end
    press(KADD);
    checks++; if (op_a !== 8'h4F) begin errors++; $display("FAIL chain_op_a got %h exp 4f", op_a); end
    checks++; if (disp !== 8'h00) begin errors++; $display("FAIL chain_b_clear got %h exp 00", disp); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL chain_state got %0d exp 1", state); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL chain_valid got %b exp 0", valid); end
    press(dig(9));
    checks++; if (disp !== 8'h09) begin errors++; $display("FAIL chain_disp got %h exp 09", disp); end
    press(KSUB);
    checks++; if (op_ci !== 1'b1) begin errors++; $display("FAIL resel_op_ci got %b exp 1", op_ci); end
    checks++; if (op_b !== 8'hF6) begin errors++; $display("FAIL resel_op_b got %h exp f6", op_b); end
    press(KEQ);
    press(dig(7));
    checks++; if (op_a !== 8'h07) begin errors++; $display("FAIL newop_op_a got %h exp 07", op_a); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL newop_state got %0d exp 0", state); end
    checks++; if (op_ci !== 1'b0) begin errors++; $display("FAIL newop_op_ci got %b exp 0", op_ci); end
  endtask

  task automatic test_priority();
    do_reset();
    press(dig(5) | dig(2));
    checks++; if (op_a !== 8'h02) begin errors++; $display("FAIL prio_digit got %h exp 02", op_a); end
    press(KADD | KSUB | dig(8));
    checks++; if (op_ci !== 1'b1) begin errors++; $display("FAIL prio_sub got %b exp 1", op_ci); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL prio_sub_state got %0d exp 1", state); end
    press(dig(7) | KCLR);
    checks++; if (op_a !== 8'h00) begin errors++; $display("FAIL prio_clr_op_a got %h exp 00", op_a); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL prio_clr_state got %0d exp 0", state); end
  endtask

  task automatic test_reset_hold();
    press(dig(1)); press(KADD); press(dig(2));
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL mid_pre_state got %0d exp 1", state); end
    @(negedge hz100);
    reset = 1'b1;
    @(negedge hz100);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL mid_reset_state got %0d exp 0", state); end
    checks++; if (op_a !== 8'h00) begin errors++; $display("FAIL mid_reset_op_a got %h exp 00", op_a); end
    keys = dig(4);
    repeat (2) @(negedge hz100);
    reset = 1'b0;
    repeat (4) @(negedge hz100);
    keys = 20'h00000;
    repeat (2) @(negedge hz100);
    checks++; if (op_a !== 8'h00) begin errors++; $display("FAIL held_key_op_a got %h exp 00", op_a); end
  endtask

  task automatic test_pulse();
    logic [7:0] exp_a;
    do_reset();
    @(negedge hz100);
    keys = dig(6);
    repeat (2) @(negedge hz100);
    keys = 20'h00000;
    repeat (2) @(negedge hz100);
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    exp_a = 8'h00;
`else
    exp_a = 8'h06;
`endif
    checks++; if (op_a !== exp_a) begin errors++; $display("FAIL pulse2_op_a got %h exp %h", op_a, exp_a); end
    @(negedge hz100);
    keys = dig(6);
    repeat (3) @(negedge hz100);
    keys = 20'h00000;
    repeat (2) @(negedge hz100);
`ifdef OPERAND_ENTRY_DEBOUNCE_EN
    exp_a = 8'h06;
`else
    exp_a = 8'h66;
`endif
    checks++; if (op_a !== exp_a) begin errors++; $display("FAIL hold3_op_a got %h exp %h", op_a, exp_a); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    keys   = 20'h00000;
    result = 8'h00;
    test_reset();
    test_add();
    test_sub();
    test_wrap();
    test_chain();
    test_priority();
    test_reset_hold();
    test_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
